// File: rtl/cgol_pkg.sv
// Shared types and rule helpers for the Game-of-Life generation engine.
package cgol_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_SCAN} state_t;

  localparam logic [8:0] B3_MASK  = 9'b000001000;
  localparam logic [8:0] S23_MASK = 9'b000001100;

  // Neighbour count n is 0..8, so it always lands inside the 9-bit rule mask.
  function automatic logic cell_next(input logic live, input logic [3:0] n,
                                     input logic [8:0] bmask, input logic [8:0] smask);
    return live ? smask[n] : bmask[n];
  endfunction
endpackage

// File: rtl/cgol_gen_engine_if.sv
// Live-cell coordinate stream: valid/ready handshake carrying (row, col).
interface cgol_gen_engine_if #(parameter int CW = 8);
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;

  modport master (output out_valid, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_row, out_col, output out_ready);
endinterface

// File: rtl/cgol_row_next.sv
// Combinational next-state for one grid row from its old neighbours above/below.
module cgol_row_next import cgol_pkg::*; #(
  parameter int         COLS         = 16,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next
);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL    = (c == 0) ? COLS-1 : c-1;
    localparam int CR    = (c == COLS-1) ? 0 : c+1;
    localparam bit HAS_L = (c > 0) || (WRAP != 0);
    localparam bit HAS_R = (c < COLS-1) || (WRAP != 0);
    logic       la, lc, lb, ra, rc, rb;
    logic [3:0] n;

    assign la = HAS_L ? above[CL] : 1'b0;
    assign lc = HAS_L ? cur[CL]   : 1'b0;
    assign lb = HAS_L ? below[CL] : 1'b0;
    assign ra = HAS_R ? above[CR] : 1'b0;
    assign rc = HAS_R ? cur[CR]   : 1'b0;
    assign rb = HAS_R ? below[CR] : 1'b0;
    assign n  = 4'(la) + 4'(above[c]) + 4'(ra) + 4'(lc) + 4'(rc)
              + 4'(lb) + 4'(below[c]) + 4'(rb);
    assign next[c] = cell_next(cur[c], n, BIRTH_MASK, SURVIVE_MASK);
  end
endmodule

// File: rtl/cgol_gen_engine.sv
// Game-of-Life engine: in-place row-serial generation stepping, then a
// row-major scan that streams live-cell coordinates with backpressure.
module cgol_gen_engine import cgol_pkg::*; #(
  parameter int         ROWS         = 16,
  parameter int         COLS         = 16,
  parameter int         CW           = 8,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_en,
  input  logic [CW-1:0]   load_row,
  input  logic [COLS-1:0] load_data,
  input  logic            start,
  input  logic [15:0]     gens,
  output logic            busy,
  output logic            done,
  output logic [15:0]     gen_count,
  cgol_gen_engine_if.master cell_out
);
  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(COLS);

  state_t                     state;
  logic [ROWS-1:0][COLS-1:0]  grid;
  logic [COLS-1:0]            prev_old, row0_save, above, below, cur, nxt;
  logic [RW-1:0]              r, r_nx, sr;
  logic [KW-1:0]              sc;
  logic [15:0]                remaining;
  logic                       scan_end, vld, last_r, advance;
  logic [CW-1:0]              orow, ocol;

  // Rows above r are already rewritten, so the old copy of row r-1 comes
  // from prev_old and the old row 0 (needed by the last row when wrapping)
  // from row0_save.
  assign last_r = (r == RW'(ROWS-1));
  assign r_nx   = last_r ? '0 : r + RW'(1);
  assign cur    = grid[r];
  assign above  = (r == '0) ? ((WRAP != 0) ? grid[ROWS-1] : '0) : prev_old;
  assign below  = last_r ? ((WRAP != 0) ? row0_save : '0) : grid[r_nx];

  cgol_row_next #(
    .COLS(COLS), .WRAP(WRAP), .BIRTH_MASK(BIRTH_MASK), .SURVIVE_MASK(SURVIVE_MASK)
  ) u_row_next (.above(above), .cur(cur), .below(below), .next(nxt));

  assign advance = !vld || cell_out.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      grid      <= '0;
      prev_old  <= '0;
      row0_save <= '0;
      r         <= '0;
      sr        <= '0;
      sc        <= '0;
      remaining <= '0;
      scan_end  <= 1'b0;
      vld       <= 1'b0;
      orow      <= '0;
      ocol      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            if (int'(load_row) < ROWS) grid[load_row[RW-1:0]] <= load_data;
            gen_count <= '0;
          end else if (start) begin
            busy      <= 1'b1;
            r         <= '0;
            sr        <= '0;
            sc        <= '0;
            scan_end  <= 1'b0;
            remaining <= gens;
            state     <= (gens != 16'd0) ? ST_STEP : ST_SCAN;
          end
        end
        ST_STEP: begin
          grid[r]  <= nxt;
          prev_old <= cur;
          if (r == '0) row0_save <= cur;
          r <= r_nx;
          if (last_r) begin
            gen_count <= gen_count + 16'd1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= ST_SCAN;
          end
        end
        ST_SCAN: if (advance) begin
          if (scan_end) begin
            vld   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            vld <= grid[sr][sc];
            if (grid[sr][sc]) begin
              orow <= CW'(sr);
              ocol <= CW'(sc);
            end
            if (sc == KW'(COLS-1)) begin
              sc <= '0;
              if (sr == RW'(ROWS-1)) scan_end <= 1'b1;
              else                   sr <= sr + RW'(1);
            end else begin
              sc <= sc + KW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cell_out.out_valid = vld;
  assign cell_out.out_row   = orow;
  assign cell_out.out_col   = ocol;
endmodule

// File: tb/tb_cgol_gen_engine.sv
// Directed bench: dead-border and toroidal engines driven in lockstep.
module tb_cgol_gen_engine;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        load_en = 1'b0, start = 1'b0, rdy = 1'b1;
  logic [7:0]  load_row = '0;
  logic [15:0] load_data = '0, gens = '0;
  logic        busy0, done0, busy1, done1;
  logic [15:0] gc0, gc1;
  int          n_chk = 0, n_err = 0, done_cyc;
  logic [15:0] got[$], exp_q[$];

  cgol_gen_engine_if #(.CW(8)) if0();
  cgol_gen_engine_if #(.CW(8)) if1();
  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;

  cgol_gen_engine #(.WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .start(start), .gens(gens), .busy(busy0),
    .done(done0), .gen_count(gc0), .cell_out(if0));
  cgol_gen_engine #(.WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .start(start), .gens(gens), .busy(busy1),
    .done(done1), .gen_count(gc1), .cell_out(if1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] row, input logic [15:0] data);
    @(negedge clk); load_en = 1'b1; load_row = row; load_data = data;
    @(negedge clk); load_en = 1'b0;
  endtask

  // Start a run, collect handshakes until done; optional stall at first valid
  // and an optional start poke while busy.
  task automatic run(input bit sel, input logic [15:0] g, input int stall, input bit poke);
    int cyc, hold;
    bit fin, stalled, v, d, b;
    logic [15:0] rc, first;
    got.delete();
    cyc = 0; hold = 0; fin = 0; stalled = 0; first = '0; done_cyc = -1;
    @(negedge clk); gens = g; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 5000) begin
      v  = sel ? if1.out_valid : if0.out_valid;
      rc = sel ? {if1.out_row, if1.out_col} : {if0.out_row, if0.out_col};
      d  = sel ? done1 : done0;
      b  = sel ? busy1 : busy0;
      if (cyc == 0) chk("busy_after_start", b, 1);
      if (poke && cyc == 10) begin start = 1'b1; gens = 16'd3; end
      else start = 1'b0;
      if (stall > 0 && v && !stalled) begin stalled = 1; hold = stall; first = rc; end
      if (hold > 0) begin
        rdy = 1'b0;
        chk("stall_valid", v, 1);
        chk("stall_rc", rc, first);
        hold--;
      end else rdy = 1'b1;
      if (v && rdy) got.push_back(rc);
      if (d) begin fin = 1; done_cyc = cyc; end
      @(negedge clk); cyc++;
    end
    start = 1'b0; rdy = 1'b1;
    if (!fin) chk("run_timeout", 0, 1);
    chk("done_pulse", sel ? done1 : done0, 0);
    chk("busy_cleared", sel ? busy1 : busy0, 0);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_cell"}, got[i], exp_q[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_done", done0, 0);
    chk("rst_gc", gc0, 0);
    chk("rst_rc", {if0.out_row, if0.out_col}, 0);
    reset_n = 1'b1;

    // Blinker, one generation
    do_reset(); load(8'd5, 16'h0070);
    run(0, 16'd1, 0, 0);
    exp_q = '{16'h0405, 16'h0505, 16'h0605}; compare("blinker");
    chk("blinker_gc", gc0, 1);

    // Still-life block in the corner, dead border
    do_reset(); load(8'd0, 16'h0003); load(8'd1, 16'h0003);
    run(0, 16'd10, 0, 0);
    exp_q = '{16'h0000, 16'h0001, 16'h0100, 16'h0101}; compare("block");
    chk("block_gc", gc0, 10);

    // Block split across all four corners of the torus
    do_reset(); load(8'd0, 16'h8001); load(8'd15, 16'h8001);
    run(1, 16'd10, 0, 0);
    exp_q = '{16'h0000, 16'h000F, 16'h0F00, 16'h0F0F}; compare("wrap_block");
    chk("wrap_block_gc", gc1, 10);

    // Glider returns home after 64 generations on a 16x16 torus
    do_reset(); load(8'd0, 16'h0002); load(8'd1, 16'h0004); load(8'd2, 16'h0007);
    run(1, 16'd64, 0, 0);
    exp_q = '{16'h0001, 16'h0102, 16'h0200, 16'h0201, 16'h0202}; compare("glider");
    chk("glider_gc", gc1, 64);

    // Backpressure: first coordinate held for 5 cycles
    do_reset(); load(8'd5, 16'h0070);
    run(0, 16'd1, 5, 0);
    exp_q = '{16'h0405, 16'h0505, 16'h0605}; compare("bp");

    // Empty grid (out-of-range load ignored), scan-only timing
    do_reset(); load(8'd16, 16'hFFFF);
    run(0, 16'd0, 0, 0);
    exp_q = {}; compare("empty");
    chk("empty_done_cyc", done_cyc, 257);
    chk("empty_gc", gc0, 0);

    // Asynchronous reset in the middle of stepping
    do_reset(); load(8'd5, 16'h0070);
    @(negedge clk); gens = 16'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy0, 1);
    reset_n = 1'b0; #1;
    chk("async_busy", busy0, 0);
    chk("async_valid", if0.out_valid, 0);
    @(negedge clk); reset_n = 1'b1;
    run(0, 16'd0, 0, 0);
    exp_q = {}; compare("post_reset");

    // Start while busy is ignored
    load(8'd5, 16'h0070);
    run(0, 16'd1, 0, 0);
    chk("pre_poke_gc", gc0, 1);
    run(0, 16'd0, 0, 1);
    exp_q = '{16'h0405, 16'h0505, 16'h0605}; compare("poke");
    chk("poke_gc", gc0, 1);
    repeat (20) @(negedge clk);
    chk("poke_idle", busy0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
